// File: rtl/plab4_net_router_pkg.sv
// Shared ring-router definitions: output port indices, one-hot request
// encodings and the route function used by input ctrl, datapath and output ctrl.
package plab4_net_router_pkg;

  localparam int PORT_WEST = 0;
  localparam int PORT_TERM = 1;
  localparam int PORT_EAST = 2;
  localparam int NUM_PORTS = 3;

  localparam logic [NUM_PORTS-1:0] REQ_NONE = 3'b000;
  localparam logic [NUM_PORTS-1:0] REQ_WEST = 3'b001;
  localparam logic [NUM_PORTS-1:0] REQ_TERM = 3'b010;
  localparam logic [NUM_PORTS-1:0] REQ_EAST = 3'b100;

  // Distance is taken mod num_routers (a power of two); a tie at exactly
  // half the ring goes east.
  function automatic logic [NUM_PORTS-1:0] route(
    input logic [31:0] dest,
    input logic [31:0] router_id,
    input logic [31:0] num_routers
  );
    logic [31:0] d;
    d = (dest - router_id) & (num_routers - 32'd1);
    if (d == 32'd0)
      route = REQ_TERM;
    else if (d <= (num_routers >> 1))
      route = REQ_EAST;
    else
      route = REQ_WEST;
  endfunction

endpackage

// File: rtl/plab4_net_router_input_ctrl_if.sv
// Handshake bundle between a router input port control and its environment:
// input channel, output-ctrl requests/grants and datapath FIFO strobes.
interface plab4_net_router_input_ctrl_if
  import plab4_net_router_pkg::*;
#(
  parameter int p_dest_nbits  = 3,
  parameter int p_count_nbits = 2
);

  logic                     in_val;
  logic                     in_rdy;
  logic [p_dest_nbits-1:0]  in_dest;
  logic [NUM_PORTS-1:0]     reqs;
  logic [NUM_PORTS-1:0]     grants;
  logic                     enq_en;
  logic                     deq_en;
  logic [p_count_nbits-1:0] count;

  modport master (
    output in_val, in_dest, grants,
    input  in_rdy, reqs, enq_en, deq_en, count
  );

  modport slave (
    input  in_val, in_dest, grants,
    output in_rdy, reqs, enq_en, deq_en, count
  );

endinterface

// File: rtl/plab4_net_router_input_queue_ctrl.sv
// Pointer/occupancy control for a small circular queue; generates the enq/deq
// strobes that drive both the dest storage and the datapath payload FIFO.
module plab4_net_router_input_queue_ctrl #(
  parameter  int p_num_entries = 2,
  localparam int PTR_NBITS     = $clog2(p_num_entries),
  localparam int CNT_NBITS     = $clog2(p_num_entries) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq_val,
  input  logic                 deq_req,
  input  logic                 bypass_ok,
  output logic                 enq_rdy,
  output logic                 enq_en,
  output logic                 deq_en,
  output logic [PTR_NBITS-1:0] wr_ptr,
  output logic [PTR_NBITS-1:0] rd_ptr,
  output logic [CNT_NBITS-1:0] count,
  output logic                 empty
);

  localparam logic [PTR_NBITS-1:0] LAST_PTR = PTR_NBITS'(p_num_entries - 1);
  localparam logic [CNT_NBITS-1:0] FULL_CNT = CNT_NBITS'(p_num_entries);

  logic [PTR_NBITS-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_NBITS-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_NBITS-1:0] count_reg, count_next;
  logic                 full;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

  // Readiness ignores grants on purpose: a full queue stays closed even when
  // its head is leaving this cycle.
  assign enq_rdy = reset & ~full;
  assign enq_en  = enq_val & enq_rdy;
  assign deq_en  = deq_req & (~empty | (bypass_ok & enq_en));

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (enq_en)
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_NBITS'(1);
    if (deq_en)
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_NBITS'(1);
    case ({enq_en, deq_en})
      2'b10:   count_next = count_reg + CNT_NBITS'(1);
      2'b01:   count_next = count_reg - CNT_NBITS'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign wr_ptr = wr_ptr_reg;
  assign rd_ptr = rd_ptr_reg;
  assign count  = count_reg;

endmodule

// File: rtl/plab4_net_router_input_ctrl.sv
// Ring-router input port control: dest FIFO, head routing and grant-driven dequeue.
// Optional same-cycle bypass of an empty queue: define PLAB4_NET_ROUTER_INPUT_BYPASS_EN.
module plab4_net_router_input_ctrl
  import plab4_net_router_pkg::*;
#(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8,
  parameter int p_num_entries = 2,
  parameter int p_dest_nbits  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  plab4_net_router_input_ctrl_if.slave  bus
);

  localparam int PTR_NBITS = $clog2(p_num_entries);
  localparam int CNT_NBITS = $clog2(p_num_entries) + 1;
  localparam logic [p_dest_nbits:0] NUM_ROUTERS_W = (p_dest_nbits + 1)'(p_num_routers);

  logic [PTR_NBITS-1:0]    wr_ptr;
  logic [PTR_NBITS-1:0]    rd_ptr;
  logic [CNT_NBITS-1:0]    count;
  logic                    empty;
  logic                    in_rdy;
  logic                    enq_en;
  logic                    deq_en;
  logic                    deq_req;
  logic                    bypass_ok;
  logic                    req_valid;
  logic [p_dest_nbits-1:0] head_dest;
  logic [p_dest_nbits-1:0] route_dest;
  logic [NUM_PORTS-1:0]    reqs;
  logic [NUM_PORTS-1:0]    granted;

  logic [p_dest_nbits-1:0] dest_mem [p_num_entries];

  plab4_net_router_input_queue_ctrl #(
    .p_num_entries (p_num_entries)
  ) queue_ctrl (
    .clk       (clk),
    .reset     (reset),
    .enq_val   (bus.in_val),
    .deq_req   (deq_req),
    .bypass_ok (bypass_ok),
    .enq_rdy   (in_rdy),
    .enq_en    (enq_en),
    .deq_en    (deq_en),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (enq_en)
      dest_mem[wr_ptr] <= bus.in_dest;
  end

  assign head_dest = dest_mem[rd_ptr];

`ifdef PLAB4_NET_ROUTER_INPUT_BYPASS_EN
  // An empty queue routes the arriving message directly; if granted, the
  // entry is written and retired in the same cycle so count stays at zero.
  assign bypass_ok  = 1'b1;
  assign req_valid  = ~empty | bus.in_val;
  assign route_dest = empty ? bus.in_dest : head_dest;
`else
  assign bypass_ok  = 1'b0;
  assign req_valid  = ~empty;
  assign route_dest = head_dest;
`endif

  always_comb begin
    reqs = REQ_NONE;
    if (reset && req_valid)
      reqs = route(32'(route_dest), 32'(p_router_id), 32'(p_num_routers));
  end

  // Only a grant on the port actually being requested retires the head.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_match
      assign granted[gi] = bus.grants[gi] & reqs[gi];
    end
  endgenerate

  assign deq_req = |granted;

  assign bus.in_rdy = in_rdy;
  assign bus.reqs   = reqs;
  assign bus.enq_en = enq_en;
  assign bus.deq_en = deq_en;
  assign bus.count  = count;

  dest_in_range: assert property (
    @(posedge clk) disable iff (!reset)
    bus.in_val |-> ({1'b0, bus.in_dest} < NUM_ROUTERS_W)
  );

endmodule

// File: doc/plab4_net_router_input_ctrl.md
Name: plab4_net_router_input_ctrl

Overview:
Per-input-port control for a ring router; counterpart of the per-output arbitration control.
- Accepts messages on a val/rdy input channel.
- Buffers each message's destination field in a small FIFO. The payload FIFO lives in the datapath and is driven by this block's enq/deq strobes.
- Computes the route for the head message and raises a one-hot request to the west, terminal, or east output control.
- Dequeues the head when the output control grants it.

Parameters:
p_router_id, 0, id of this router on the ring
p_num_routers, 8, ring size; must be a power of two, at least 2
p_num_entries, 2, FIFO depth; 2 to 8
p_dest_nbits, 3, width of the dest field; equals clog2(p_num_routers)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
in_val  input  1  incoming message valid
in_rdy  output  1  block can accept a message
in_dest  input  p_dest_nbits  destination router of the incoming message
reqs  output  3  one-hot request: bit0 west/prev, bit1 terminal, bit2 east/next
grants  input  3  grant from the output controls; at most one bit set
enq_en  output  1  datapath payload FIFO write strobe
deq_en  output  1  datapath payload FIFO read strobe
count  output  clog2(p_num_entries)+1  current occupancy

Behaviour:
- Reset (reset==0, asynchronous): count=0, read/write pointers=0, FIFO contents don't-care. While reset is held: in_rdy=0, reqs=0, enq_en=0, deq_en=0.
- Reset mid-operation discards all buffered messages. No request is asserted until after reset deasserts and a new enqueue occurs.
- in_rdy = (count != p_num_entries). It deliberately does not depend on grants, so there is no combinational path from grants to in_rdy. When full, a same-cycle dequeue does not open a slot.
- enq_en = in_val & in_rdy. The dest is written at the write pointer and the pointer increments, wrapping p_num_entries-1 -> 0. Non-power-of-two depths use explicit wrap.
- Head valid = (count != 0). reqs = route(head_dest) when head is valid, else 0.
- Route function, mod-N arithmetic: d = (head_dest - p_router_id) mod p_num_routers, computed in p_dest_nbits bits.
  - d==0 -> 3'b010 (terminal).
  - 0 < d <= p_num_routers/2 -> 3'b100 (east). The tie at exactly N/2 goes east.
  - otherwise -> 3'b001 (west).
- deq_en = |(grants & reqs). Grants not matching the current request are ignored. The read pointer increments with wrap.
- reqs stays asserted and stable until deq_en. The next head's request appears the cycle after dequeue, so one message is moved per cycle per port at most.
- count update:
  - enq only: +1
  - deq only: -1
  - both: unchanged
- No-bypass latency: a message enqueued at cycle t raises reqs at t+1 at the earliest.
- Simultaneous enq and deq with count==1 is legal. The new entry becomes head next cycle.
- in_dest values >= p_num_routers are illegal; behaviour is undefined. An assertion fires in simulation.

Optional Feature:
PLAB4_NET_ROUTER_INPUT_BYPASS_EN
- Defined: when count==0 and in_val, reqs = route(in_dest) in the same cycle. If the route is granted that cycle, deq_en and enq_en both pulse, pointers advance together, and count stays 0. The datapath uses the bypass mux for payload. Latency is 0 cycles.
- Not defined: reqs derives only from the FIFO head. Latency is at least 1 cycle. in_val never reaches reqs combinationally.

Decomposition:
- Shared package plab4_net_router_pkg holds:
  - port index constants: PORT_WEST=0, PORT_TERM=1, PORT_EAST=2
  - NUM_PORTS=3
  - the route function, shared with the datapath and output ctrl tests
- Sub-module plab4_net_router_input_queue_ctrl holds pointers, count, full/empty, and enq/deq strobes, and is reused by the datapath queue.
- The top level adds the dest storage, the route logic, and the bypass.

Test Plan:
- Reset then idle: with reset low, in_rdy=0 and reqs=0. After release: in_rdy=1, count=0, reqs=0.
- Routing, id=0, N=8:
  - dest 0 -> reqs=3'b010
  - dest 3 -> 3'b100
  - dest 4 -> 3'b100 (tie)
  - dest 5 -> 3'b001
  - Each request clears the cycle after a matching grant.
- Wrong or absent grant: head dest 2 (east), grants=3'b001 for 3 cycles -> reqs stays 3'b100, deq_en=0. grants=3'b100 -> deq_en=1 that cycle.
- Full backpressure, depth 2: enqueue 2 with no grants -> count=2, in_rdy=0. Grant head with in_val=1 -> count=1 and no enq that cycle; in_rdy=1 next cycle.
- Simultaneous enq/deq at count=1: dests 1 then 7 with id=0 -> count stays 1, next reqs=3'b001. Pointers wrap correctly over 10 messages.
- Async reset mid-stream: count=2, drop reset between clock edges -> reqs=0 and in_rdy=0 immediately. After release, count=0. With bypass enabled, empty FIFO plus dest 0 -> reqs=3'b010 in the same cycle.
